// File: rtl/trng_cond_ctrl_if.sv
// Bus bundle between the conditioning controller and its neighbours:
// raw entropy input, Keccak permutation port and key read port.
interface trng_cond_ctrl_if #(
  parameter int unsigned RAW_W     = 1000,
  parameter int unsigned NBITS_KEY = 32
);

  localparam int unsigned KcW = 1600;

  // Raw entropy from the TRNG core
  logic                 raw_valid;
  logic [RAW_W-1:0]     raw_data;
  logic                 raw_ack;

  // Keccak permutation
  logic                 kc_start;
  logic [KcW-1:0]       kc_din;
  logic [KcW-1:0]       kc_dout;
  logic                 kc_done;

  // Key read side
  logic                 key_valid;
  logic [NBITS_KEY-1:0] key_out;
  logic                 key_ack;
  logic                 key_intr;

  // Controller side
  modport master (
    input  raw_valid, raw_data, kc_dout, kc_done, key_ack,
    output raw_ack, kc_start, kc_din, key_valid, key_out, key_intr
  );

  // Environment side (TRNG core, Keccak, key consumer)
  modport slave (
    output raw_valid, raw_data, kc_dout, kc_done, key_ack,
    input  raw_ack, kc_start, kc_din, key_valid, key_out, key_intr
  );

endinterface

// File: rtl/trng_cond_ctrl.sv
// TRNG conditioning controller: accepts raw entropy words, runs a repetition-count
// health test, emits keys either raw or via one Keccak permutation, and buffers
// the keys in a small FIFO read through a valid/ack handshake.
module trng_cond_ctrl #(
  parameter int unsigned RAW_W      = 1000,
  parameter int unsigned NBITS_KEY  = 32,
  parameter int unsigned KEY_OFFSET = 815,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REP_LIMIT  = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             conditioning,
  input  logic             err_clr,
  output logic             health_alarm,
  output logic             perm_err,
  trng_cond_ctrl_if.master bus
);

  localparam int unsigned KcW  = 1600;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RunW = $clog2(REP_LIMIT + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);
  localparam logic [RunW-1:0] RunLimit = RunW'(REP_LIMIT);
  localparam logic [RunW-1:0] RunOne   = RunW'(1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait
  } state_e;

  // FSM
  state_e              state_q, state_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;

  // Health test history and latched Keccak input
  logic [RAW_W-1:0]    last_q, last_d;
  logic [RunW-1:0]     run_q, run_d;
  logic [KcW-1:0]      kc_din_q, kc_din_d;

  // Sticky error flags
  logic                alarm_q, alarm_d;
  logic                perr_q, perr_d;

  // Key FIFO
  logic [NBITS_KEY-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 intr_q;

  // Control strobes
  logic                 fifo_full, fifo_empty;
  logic                 accept, push, pop;
  logic                 rep_hit, set_alarm, set_perr;
  logic [RunW-1:0]      run_inc;
  logic [NBITS_KEY-1:0] push_data;

  // Only the key slice of the permutation result is consumed.
  logic                 unused_kc_dout;
  assign unused_kc_dout = ^bus.kc_dout;

  // FIFO status and the IDLE acceptance gate; reset blocks acceptance so raw_ack stays low.
  always_comb begin
    fifo_full  = (cnt_q == FifoFull);
    fifo_empty = (cnt_q == '0);
    pop        = bus.key_ack && !fifo_empty;
    accept     = rst_n && (state_q == StIdle) && enable && bus.raw_valid &&
                 !fifo_full && !alarm_q;
  end

  // Repetition run length the incoming word would produce if accepted.
  // A zero run count means no history, so the first word never matches.
  always_comb begin
    rep_hit = (run_q != '0) && (bus.raw_data == last_q);
    run_inc = rep_hit ? (run_q + 1'b1) : RunOne;
  end

  // Next-state logic: accept/route in IDLE, single start pulse, bounded wait for kc_done.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    push      = 1'b0;
    push_data = '0;
    set_alarm = 1'b0;
    set_perr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (run_inc >= RunLimit) begin
            // Failing word is dropped: neither pushed nor conditioned.
            set_alarm = 1'b1;
          end else if (!conditioning) begin
            push      = 1'b1;
            push_data = bus.raw_data[NBITS_KEY-1:0];
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        state_d = StWait;
        tmo_d   = '0;
      end
      StWait: begin
        if (bus.kc_done) begin
          push      = 1'b1;
          push_data = bus.kc_dout[KEY_OFFSET +: NBITS_KEY];
          state_d   = StIdle;
        end else if (tmo_q == TmoLast) begin
          set_perr = 1'b1;
          state_d  = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Health history, Keccak input latch and sticky flags; err_clr overrides a same-cycle set.
  always_comb begin
    last_d   = last_q;
    run_d    = run_q;
    kc_din_d = kc_din_q;
    alarm_d  = alarm_q | set_alarm;
    perr_d   = perr_q | set_perr;
    if (accept) begin
      last_d                 = bus.raw_data;
      run_d                  = run_inc;
      kc_din_d               = '0;
      kc_din_d[RAW_W-1:0]    = bus.raw_data;
    end
    if (err_clr) begin
      alarm_d = 1'b0;
      perr_d  = 1'b0;
      run_d   = '0;
      last_d  = '0;
    end
  end

  // FIFO pointer and occupancy update; simultaneous push and pop leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // FSM state and timeout counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // Health history, Keccak input and error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q   <= '0;
      run_q    <= '0;
      kc_din_q <= '0;
      alarm_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      last_q   <= last_d;
      run_q    <= run_d;
      kc_din_q <= kc_din_d;
      alarm_q  <= alarm_d;
      perr_q   <= perr_d;
    end
  end

  // FIFO pointers, occupancy and the key interrupt pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      intr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      intr_q   <= push;
    end
  end

  // FIFO storage; entries are not reset because key_out is masked while empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Output drive.
  always_comb begin
    bus.raw_ack   = accept;
    bus.kc_start  = (state_q == StStart);
    bus.kc_din    = kc_din_q;
    bus.key_valid = !fifo_empty;
    bus.key_out   = fifo_empty ? '0 : mem_q[rd_ptr_q];
    bus.key_intr  = intr_q;
    health_alarm  = alarm_q;
    perm_err      = perr_q;
  end

endmodule
